// File: rtl/echo_measure_if.sv
// Result/handshake bundle between the TRIG generator, the ECHO pin and the
// distance consumer.
interface echo_measure_if;
    logic        trig;
    logic        echo;
    logic [15:0] dist_mm;
    logic        dist_valid;
    logic        timeout;
    logic        busy;

    modport master (
        output trig, echo,
        input  dist_mm, dist_valid, timeout, busy
    );

    modport slave (
        input  trig, echo,
        output dist_mm, dist_valid, timeout, busy
    );
endinterface

// File: rtl/echo_measure.sv
// Times the ultrasonic ECHO high pulse after a TRIG falling edge and converts
// it to millimetres with a serial restoring divider.
module echo_measure #(
    parameter int unsigned CLK_PER_US      = 12,
    parameter int unsigned WAIT_TIMEOUT_US = 2000,
    parameter int unsigned ECHO_TIMEOUT_US = 30000,
    parameter int unsigned MM_NUM          = 17,
    parameter int unsigned MM_DEN          = 100
) (
    input logic           clk,
    input logic           rst,
    echo_measure_if.slave bus
);

    localparam int unsigned PreW     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_PER_US - 1);
    localparam logic [4:0]  LastStep = 5'd19;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWait    = 3'd1;
    localparam logic [2:0] StMeasure = 3'd2;
    localparam logic [2:0] StCalc    = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            echo_meta_q, echo_s_q, echo_d_q, trig_d_q;
    logic [PreW-1:0] pre_q, pre_d;
    logic [14:0]     us_cnt_q, us_cnt_d;
    logic [19:0]     quot_q, quot_d;
    logic [7:0]      rem_q, rem_d;
    logic [4:0]      iter_q, iter_d;
    logic [15:0]     dist_q, dist_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;

    logic        rise, fall, arm, us_tick;
    logic [14:0] us_next;
    logic [8:0]  trial;
    logic        trial_ge;

    assign rise     = echo_s_q & ~echo_d_q;
    assign fall     = ~echo_s_q & echo_d_q;
    assign arm      = trig_d_q & ~bus.trig;
    assign us_tick  = (pre_q == PreMax);
    // Count including a tick landing on this edge, so a fall on the tick
    // still credits the completed microsecond.
    assign us_next  = us_cnt_q + 15'(us_tick);
    assign trial    = {rem_q, quot_q[19]};
    assign trial_ge = (trial >= 9'(MM_DEN));

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        us_cnt_d  = us_cnt_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        iter_d    = iter_q;
        dist_d    = dist_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d  = StWait;
                    pre_d    = '0;
                    us_cnt_d = '0;
                end
            end
            StWait: begin
                pre_d    = us_tick ? '0 : pre_q + 1'b1;
                us_cnt_d = us_next;
                if (rise) begin
                    state_d  = StMeasure;
                    pre_d    = '0;
                    us_cnt_d = '0;
                end else if (us_tick && us_next == 15'(WAIT_TIMEOUT_US)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StMeasure: begin
                pre_d    = us_tick ? '0 : pre_q + 1'b1;
                us_cnt_d = us_next;
                if (fall) begin
                    state_d = StCalc;
                    quot_d  = 20'(32'(us_next) * MM_NUM);
                    rem_d   = '0;
                    iter_d  = '0;
                end else if (us_tick && us_next == 15'(ECHO_TIMEOUT_US)) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
            StCalc: begin
                // Dividend shifts out of quot_q MSB-first as quotient bits shift in.
                rem_d  = trial_ge ? 8'(trial - 9'(MM_DEN)) : trial[7:0];
                quot_d = {quot_q[18:0], trial_ge};
                iter_d = iter_q + 1'b1;
                if (iter_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                dist_d  = quot_q[15:0];
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_d_q    <= 1'b0;
            trig_d_q    <= 1'b0;
            pre_q       <= '0;
            us_cnt_q    <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            iter_q      <= '0;
            dist_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            echo_meta_q <= bus.echo;
            echo_s_q    <= echo_meta_q;
            echo_d_q    <= echo_s_q;
            trig_d_q    <= bus.trig;
            pre_q       <= pre_d;
            us_cnt_q    <= us_cnt_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            iter_q      <= iter_d;
            dist_q      <= dist_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.dist_mm    = dist_q;
    assign bus.dist_valid = valid_q;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_echo_measure.sv
// Self-checking bench for echo_measure with shortened timeouts; expectations
// come from pulse widths in cycles through plain arithmetic.
module tb_echo_measure;

    localparam int CPU        = 4;
    localparam int WAIT_US    = 100;
    localparam int ECHO_TO_US = 1500;

    logic clk = 1'b0;
    logic rst = 1'b1;

    echo_measure_if bus ();

    echo_measure #(
        .CLK_PER_US      (CPU),
        .WAIT_TIMEOUT_US (WAIT_US),
        .ECHO_TIMEOUT_US (ECHO_TO_US),
        .MM_NUM          (17),
        .MM_DEN          (100)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vcnt = 0, tcnt = 0, v_cyc = 0, t_cyc = 0, both_cnt = 0;
    logic [15:0] v_dist = '0;
    always @(negedge clk) begin
        if (bus.dist_valid) begin
            vcnt   <= vcnt + 1;
            v_cyc  <= cyc;
            v_dist <= bus.dist_mm;
        end
        if (bus.timeout) begin
            tcnt  <= tcnt + 1;
            t_cyc <= cyc;
        end
        if (bus.dist_valid && bus.timeout) both_cnt <= both_cnt + 1;
    end

    int checks = 0, errors = 0;
    int exp_last = 0;
    int arm_cyc = 0;

    function automatic int exp_dist(input int width);
        return ((width / CPU) * 17) / 100;
    endfunction

    function automatic bit exp_timeout(input int width);
        return width > ECHO_TO_US * CPU;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        bus.trig = 1'b1;
        step(2);
        bus.trig = 1'b0;
        arm_cyc = cyc + 1;
    endtask

    // Returns k: the first edge that samples echo low.
    task automatic run_pulse(input int pre, input int width, output int k);
        do_arm();
        step(pre);
        bus.echo = 1'b1;
        step(width);
        bus.echo = 1'b0;
        k = cyc + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks += 4;
        if (bus.dist_mm !== 16'd0) begin
            errors++; $display("FAIL reset_dist got %0d expected 0", bus.dist_mm);
        end
        if (bus.dist_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b expected 0", bus.dist_valid);
        end
        if (bus.timeout !== 1'b0) begin
            errors++; $display("FAIL reset_timeout got %0b expected 0", bus.timeout);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %0b expected 0", bus.busy);
        end
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_basic();
        int v0, t0, k, w;
        v0 = vcnt; t0 = tcnt; w = 580 * CPU;
        do_arm();
        step(1);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_arm got %0b expected 1", bus.busy);
        end
        step(20);
        bus.echo = 1'b1;
        step(w);
        bus.echo = 1'b0;
        k = cyc + 1;
        step(30);
        exp_last = exp_dist(w);
        checks += 5;
        if (vcnt != v0 + 1) begin
            errors++; $display("FAIL basic_valid_count got %0d expected %0d", vcnt - v0, 1);
        end
        if (tcnt != t0) begin
            errors++; $display("FAIL basic_timeout_count got %0d expected 0", tcnt - t0);
        end
        if (v_dist !== 16'(exp_last)) begin
            errors++; $display("FAIL basic_dist got %0d expected %0d", v_dist, exp_last);
        end
        if (v_cyc != k + 23) begin
            errors++; $display("FAIL basic_latency got edge %0d expected %0d", v_cyc, k + 23);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL basic_busy_end got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_dist_values();
        int widths [2];
        widths[0] = 1000 * CPU;
        widths[1] = CPU - 1;
        foreach (widths[i]) begin
            int v0, k;
            v0 = vcnt;
            run_pulse(15, widths[i], k);
            step(30);
            exp_last = exp_dist(widths[i]);
            checks += 2;
            if (vcnt != v0 + 1) begin
                errors++; $display("FAIL dist_count[%0d] got %0d expected 1", i, vcnt - v0);
            end
            if (bus.dist_mm !== 16'(exp_last)) begin
                errors++;
                $display("FAIL dist_value[%0d] got %0d expected %0d", i, bus.dist_mm, exp_last);
            end
        end
    endtask

    task automatic test_wait_timeout();
        int v0, t0, a, dt;
        v0 = vcnt; t0 = tcnt;
        do_arm();
        a = arm_cyc;
        step(WAIT_US * CPU + 10);
        dt = t_cyc - (a + WAIT_US * CPU);
        checks += 5;
        if (tcnt != t0 + 1) begin
            errors++; $display("FAIL wait_to_count got %0d expected 1", tcnt - t0);
        end
        if (vcnt != v0) begin
            errors++; $display("FAIL wait_to_valid got %0d expected 0", vcnt - v0);
        end
        if (dt < -2 || dt > 2) begin
            errors++;
            $display("FAIL wait_to_time got edge %0d expected %0d", t_cyc, a + WAIT_US * CPU);
        end
        if (bus.dist_mm !== 16'(exp_last)) begin
            errors++; $display("FAIL wait_to_dist got %0d expected %0d", bus.dist_mm, exp_last);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL wait_to_busy got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_echo_limits();
        int widths [4];
        widths[0] = 2000 * CPU;
        widths[1] = ECHO_TO_US * CPU;
        widths[2] = (ECHO_TO_US - 1) * CPU;
        widths[3] = ECHO_TO_US * CPU + 1;
        foreach (widths[i]) begin
            int v0, t0, k;
            bit to;
            v0 = vcnt; t0 = tcnt;
            run_pulse(10, widths[i], k);
            step(30);
            to = exp_timeout(widths[i]);
            if (!to) exp_last = exp_dist(widths[i]);
            checks += 4;
            if (tcnt != t0 + (to ? 1 : 0)) begin
                errors++;
                $display("FAIL limit_to[%0d] got %0d expected %0d", i, tcnt - t0, to ? 1 : 0);
            end
            if (vcnt != v0 + (to ? 0 : 1)) begin
                errors++;
                $display("FAIL limit_valid[%0d] got %0d expected %0d", i, vcnt - v0, to ? 0 : 1);
            end
            if (bus.dist_mm !== 16'(exp_last)) begin
                errors++;
                $display("FAIL limit_dist[%0d] got %0d expected %0d", i, bus.dist_mm, exp_last);
            end
            if (bus.busy !== 1'b0) begin
                errors++; $display("FAIL limit_busy[%0d] got %0b expected 0", i, bus.busy);
            end
        end
    endtask

    task automatic test_echo_high_at_arm();
        int v0, t0, w;
        v0 = vcnt; t0 = tcnt; w = 100 * CPU;
        bus.echo = 1'b1;
        step(3);
        do_arm();
        step(40);
        bus.echo = 1'b0;
        step(20);
        bus.echo = 1'b1;
        step(w);
        bus.echo = 1'b0;
        // Second arm lands while the divider is running.
        step(7);
        bus.trig = 1'b1;
        step(1);
        bus.trig = 1'b0;
        step(60);
        exp_last = exp_dist(w);
        checks += 4;
        if (vcnt != v0 + 1) begin
            errors++; $display("FAIL high_arm_count got %0d expected 1", vcnt - v0);
        end
        if (tcnt != t0) begin
            errors++; $display("FAIL high_arm_timeout got %0d expected 0", tcnt - t0);
        end
        if (bus.dist_mm !== 16'(exp_last)) begin
            errors++; $display("FAIL high_arm_dist got %0d expected %0d", bus.dist_mm, exp_last);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL high_arm_busy got %0b expected 0", bus.busy);
        end
    endtask

    task automatic test_reset_abort();
        int v0, t0, k;
        run_pulse(10, 500 * CPU, k);
        step(30);
        v0 = vcnt; t0 = tcnt;
        do_arm();
        step(10);
        bus.echo = 1'b1;
        step(200);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_last = 0;
        checks += 2;
        if (bus.dist_mm !== 16'd0) begin
            errors++; $display("FAIL abort_meas_dist got %0d expected 0", bus.dist_mm);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_meas_busy got %0b expected 0", bus.busy);
        end
        bus.echo = 1'b0;
        step(40);
        run_pulse(10, 300 * CPU, k);
        step(10);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL abort_calc_busy_pre got %0b expected 1", bus.busy);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(40);
        checks += 4;
        if (vcnt != v0 || tcnt != t0) begin
            errors++;
            $display("FAIL abort_pulses got valid %0d timeout %0d expected 0 0",
                     vcnt - v0, tcnt - t0);
        end
        if (bus.dist_mm !== 16'd0) begin
            errors++; $display("FAIL abort_calc_dist got %0d expected 0", bus.dist_mm);
        end
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_calc_busy got %0b expected 0", bus.busy);
        end
        if (bus.dist_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got valid %0b timeout %0b expected 0 0",
                     bus.dist_valid, bus.timeout);
        end
        v0 = vcnt;
        run_pulse(10, 300 * CPU, k);
        step(30);
        exp_last = exp_dist(300 * CPU);
        checks += 2;
        if (vcnt != v0 + 1) begin
            errors++; $display("FAIL abort_recover_count got %0d expected 1", vcnt - v0);
        end
        if (bus.dist_mm !== 16'(exp_last)) begin
            errors++;
            $display("FAIL abort_recover_dist got %0d expected %0d", bus.dist_mm, exp_last);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int v0, t0, k, w, pre;
            w   = int'($urandom_range(1, 700 * CPU));
            pre = int'($urandom_range(1, 200));
            v0 = vcnt; t0 = tcnt;
            run_pulse(pre, w, k);
            step(30);
            exp_last = exp_dist(w);
            checks += 3;
            if (vcnt != v0 + 1 || tcnt != t0) begin
                errors++;
                $display("FAIL rand_count[%0d] w=%0d got valid %0d timeout %0d expected 1 0",
                         i, w, vcnt - v0, tcnt - t0);
            end
            if (v_dist !== 16'(exp_last)) begin
                errors++;
                $display("FAIL rand_dist[%0d] w=%0d got %0d expected %0d", i, w, v_dist, exp_last);
            end
            if (v_cyc != k + 23) begin
                errors++;
                $display("FAIL rand_latency[%0d] got edge %0d expected %0d", i, v_cyc, k + 23);
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt != 0) begin
            errors++; $display("FAIL exclusive_pulses got %0d overlaps expected 0", both_cnt);
        end
    endtask

    initial begin
        bus.trig = 1'b0;
        bus.echo = 1'b0;
        test_reset();
        test_basic();
        test_dist_values();
        test_wait_timeout();
        test_echo_limits();
        test_echo_high_at_arm();
        test_reset_abort();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
